// File: rtl/char_ctl.sv
// Frame-rate character motion: buttons -> sprite centre, facing bit and
// jump/fall arc, clamped to the screen edges and the ground line.
module char_ctl #(
    parameter int HOR_PIXELS = 1024,
    parameter int VER_PIXELS = 768,
    parameter int X_SPEED    = 4,
    parameter int JUMP_VEL   = 14,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 12,
    parameter int GROUND_Y   = VER_PIXELS - 20,
    parameter int INIT_HGT   = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [11:0] char_hgt,
    input  logic [11:0] char_lng,
    output logic [11:0] pos_x,
    output logic [11:0] pos_y,
    output logic        flip_h,
    output logic        on_ground
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    localparam logic signed [7:0] G_S    = 8'(GRAVITY);
    localparam logic signed [7:0] MAXF_S = 8'(MAX_FALL);

    state_t             state;
    logic signed [7:0]  vel_y;
    logic               jump_req, jump_d;
    logic               jump_edge, jump_now;
    logic [11:0]        gy, x_left, x_right, x_max;
    logic signed [7:0]  vel_rise, vel_fall;
    logic [12:0]        y_fall_sum;
    logic               ceiling_hit;

    // All edge comparisons are done one bit wider so nothing wraps.
    always_comb begin
        jump_edge   = btn_jump & ~jump_d;
        jump_now    = jump_req | jump_edge;
        gy          = 12'(GROUND_Y) - char_hgt;
        x_left      = ({1'b0, pos_x} >= {1'b0, char_lng} + 13'(X_SPEED))
                      ? pos_x - 12'(X_SPEED) : char_lng;
        x_max       = 12'(HOR_PIXELS - 1) - char_lng;
        x_right     = ({1'b0, pos_x} + 13'(X_SPEED) <= {1'b0, x_max})
                      ? pos_x + 12'(X_SPEED) : x_max;
        vel_rise    = vel_y - G_S;
        vel_fall    = (vel_y >= MAXF_S - G_S) ? MAXF_S : vel_y + G_S;
        y_fall_sum  = {1'b0, pos_y} + {5'b0, vel_fall};
        ceiling_hit = {1'b0, pos_y} < ({1'b0, char_hgt} + {6'b0, vel_y[6:0]});
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_x     <= 12'(HOR_PIXELS / 2);
            pos_y     <= 12'(GROUND_Y - INIT_HGT);
            flip_h    <= 1'b0;
            state     <= GROUND;
            on_ground <= 1'b1;
            vel_y     <= '0;
            jump_req  <= 1'b0;
            jump_d    <= 1'b0;
        end else begin
            jump_d <= btn_jump;
            if (frame_tick) begin
                jump_req <= 1'b0;
                if (btn_left && !btn_right) begin
                    flip_h <= 1'b1;
                    pos_x  <= x_left;
                end else if (btn_right && !btn_left) begin
                    flip_h <= 1'b0;
                    pos_x  <= x_right;
                end
                case (state)
                    GROUND: begin
                        if (jump_now) begin
                            vel_y     <= 8'(JUMP_VEL - GRAVITY);
                            pos_y     <= pos_y - 12'(JUMP_VEL);
                            state     <= RISE;
                            on_ground <= 1'b0;
                        end else begin
                            pos_y <= gy;
                        end
                    end
                    RISE: begin
                        if (ceiling_hit) begin
                            pos_y <= char_hgt;
                            vel_y <= '0;
                            state <= FALL;
                        end else begin
                            pos_y <= pos_y - {5'b0, vel_y[6:0]};
                            if (vel_rise <= 0) begin
                                vel_y <= '0;
                                state <= FALL;
                            end else begin
                                vel_y <= vel_rise;
                            end
                        end
                    end
                    FALL: begin
                        if (y_fall_sum >= {1'b0, gy}) begin
                            pos_y     <= gy;
                            vel_y     <= '0;
                            state     <= GROUND;
                            on_ground <= 1'b1;
                        end else begin
                            pos_y <= pos_y + {4'b0, vel_fall};
                            vel_y <= vel_fall;
                        end
                    end
                    default: begin
                        state     <= GROUND;
                        on_ground <= 1'b1;
                        vel_y     <= '0;
                    end
                endcase
            end else if (jump_edge) begin
                jump_req <= 1'b1;
            end
        end
    end

endmodule
